// File: rtl/bank_rd_sched_pkg.sv
// Shared widths and address decode helpers for the banked read scheduler.
package bank_rd_sched_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   function automatic int unsigned addr_bank(input int unsigned addr, input int unsigned words);
      return addr / words;
   endfunction

   function automatic int unsigned addr_offset(input int unsigned addr, input int unsigned words);
      return addr % words;
   endfunction

endpackage

// File: rtl/bank_rd_sched_rr_arb.sv
// Round-robin arbiter for one bank: one-hot grant, search starts at the rotating pointer.
module rr_arb #(
   parameter  int N  = 8,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
            ptr_d    = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bank_rd_sched.sv
// Multi-port read scheduler over contiguous memory banks with per-bank round-robin arbitration.
// Optional per-bank conflict statistics are enabled by defining BANK_RD_SCHED_STATS_EN.
module bank_rd_sched
   import bank_rd_sched_pkg::*;
#(
   parameter  int NUM_BANKS          = 3,
   parameter  int SIZE_BANKI         = 32,
   parameter  int NUM_RD_PORTS       = 8,
   localparam int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
   localparam int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI*NUM_BANKS)
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [NUM_RD_PORTS-1:0]                            req_cpu,
   input  logic [NUM_RD_PORTS-1:0][SHIRINA_VSEH_BANOK-1:0]    ra,
   output logic [NUM_RD_PORTS-1:0]                            gnt_cpu,
   output logic [NUM_RD_PORTS-1:0]                            rvalid_cpu,
   output logic [NUM_RD_PORTS-1:0]                            rerr_cpu,
   output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]                rd_cpu,
   output logic [NUM_BANKS-1:0]                               bank_en,
   output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]            bank_adr,
   input  logic [NUM_BANKS-1:0][DATA_W-1:0]                   bank_rd
`ifdef BANK_RD_SCHED_STATS_EN
   ,
   output logic [NUM_BANKS-1:0][CNT_W-1:0]                    conflict_cnt
`endif
);

   localparam int unsigned TOTAL_WORDS = NUM_BANKS * SIZE_BANKI;

   int unsigned                                 port_bank [NUM_RD_PORTS];
   logic [NUM_RD_PORTS-1:0][SHIRINA_BANKI-1:0]  port_off;
   logic [NUM_RD_PORTS-1:0]                     in_rng;
   logic [NUM_RD_PORTS-1:0]                     oor_req;
   logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]      bank_req;
   logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]      bank_gnt;

   logic [NUM_RD_PORTS-1:0]                     rvalid_q, rvalid_d;
   logic [NUM_RD_PORTS-1:0]                     rerr_q, rerr_d;
   logic [NUM_RD_PORTS-1:0][DATA_W-1:0]         rd_q, rd_d;

   always_comb begin
      in_rng   = '0;
      oor_req  = '0;
      bank_req = '0;
      port_off = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         port_bank[p] = addr_bank(32'(ra[p]), SIZE_BANKI);
         port_off[p]  = SHIRINA_BANKI'(addr_offset(32'(ra[p]), SIZE_BANKI));
         in_rng[p]    = 32'(ra[p]) < TOTAL_WORDS;
         oor_req[p]   = req_cpu[p] & ~in_rng[p];
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (req_cpu[p] && in_rng[p] && (port_bank[p] == 32'(b))) begin
               bank_req[b][p] = 1'b1;
            end
         end
      end
   end

   for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_arb
      rr_arb #(.N(NUM_RD_PORTS)) u_arb (
         .clk (clk),
         .rst (rst),
         .req (bank_req[gb]),
         .gnt (bank_gnt[gb])
      );
   end

   // Out-of-range requests bypass the banks and are granted unconditionally.
   always_comb begin
      gnt_cpu  = '0;
      bank_en  = '0;
      bank_adr = '0;
      if (rst) begin
         gnt_cpu = oor_req;
         for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b] = |bank_gnt[b];
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
               if (bank_gnt[b][p]) begin
                  gnt_cpu[p]  = 1'b1;
                  bank_adr[b] = port_off[p];
               end
            end
         end
      end
   end

   always_comb begin
      rvalid_d = gnt_cpu;
      rerr_d   = gnt_cpu & oor_req;
      rd_d     = rd_q;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         if (gnt_cpu[p]) begin
            rd_d[p] = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
               if (in_rng[p] && (port_bank[p] == 32'(b))) begin
                  rd_d[p] = bank_rd[b];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rvalid_q <= '0;
         rerr_q   <= '0;
         rd_q     <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rd_q     <= rd_d;
      end
   end

   // A read granted just before reset must not surface while reset is asserted.
   assign rvalid_cpu = rvalid_q & {NUM_RD_PORTS{rst}};
   assign rerr_cpu   = rerr_q & {NUM_RD_PORTS{rst}};
   assign rd_cpu     = rd_q;

`ifdef BANK_RD_SCHED_STATS_EN
   logic [NUM_BANKS-1:0][CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if ($countones(bank_req[b]) >= 2) begin
            cnt_d[b] = sat_inc(cnt_q[b]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bank_rd_sched.sv
// Testbench for bank_rd_sched: directed scenarios plus randomized traffic against a reference model.
module tb_bank_rd_sched;
   import bank_rd_sched_pkg::*;

   localparam int NB = 3;
   localparam int SB = 32;
   localparam int NP = 4;
   localparam int AW = 7;
   localparam int OW = 5;
   localparam int TOT = NB * SB;

   logic                       clk;
   logic                       rst;
   logic [NP-1:0]              req;
   logic [NP-1:0][AW-1:0]      ra;
   logic [NP-1:0]              gnt_cpu, rvalid_cpu, rerr_cpu;
   logic [NP-1:0][31:0]        rd_cpu;
   logic [NB-1:0]              bank_en;
   logic [NB-1:0][OW-1:0]      bank_adr;
   logic [NB-1:0][31:0]        bank_rd;
`ifdef BANK_RD_SCHED_STATS_EN
   logic [NB-1:0][15:0]        conflict_cnt;
`endif

   logic [31:0] mem [NB][SB];
   int n_checks = 0;
   int n_fail   = 0;

   bank_rd_sched #(.NUM_BANKS(NB), .SIZE_BANKI(SB), .NUM_RD_PORTS(NP)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_cpu    (req),
      .ra         (ra),
      .gnt_cpu    (gnt_cpu),
      .rvalid_cpu (rvalid_cpu),
      .rerr_cpu   (rerr_cpu),
      .rd_cpu     (rd_cpu),
      .bank_en    (bank_en),
      .bank_adr   (bank_adr),
      .bank_rd    (bank_rd)
`ifdef BANK_RD_SCHED_STATS_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int b = 0; b < NB; b++) bank_rd[b] = mem[b][bank_adr[b]];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0;
      ra  = '0;
      next_cycle();
      next_cycle();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req = NP'($urandom);
         ra  = (NP*AW)'($urandom);
         @(negedge clk);
         n_checks++;
         if (gnt_cpu !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", gnt_cpu); end
         n_checks++;
         if (bank_en !== '0) begin n_fail++; $display("FAIL rst_bank_en: got %b want 0", bank_en); end
         n_checks++;
         if (bank_adr !== '0) begin n_fail++; $display("FAIL rst_bank_adr: got %h want 0", bank_adr); end
         next_cycle();
      end
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      n_checks++;
      if (rvalid_cpu !== '0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", rvalid_cpu); end
      n_checks++;
      if (rerr_cpu !== '0) begin n_fail++; $display("FAIL rst_rerr: got %b want 0", rerr_cpu); end
      n_checks++;
      if (rd_cpu !== '0) begin n_fail++; $display("FAIL rst_rd: got %h want 0", rd_cpu); end
      next_cycle();
   endtask

   task automatic test_single();
      do_reset();
      ra[0] = 7'd5;
      req   = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (gnt_cpu !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt_cpu); end
      n_checks++;
      if (bank_en !== 3'b001) begin n_fail++; $display("FAIL single_en: got %b want 001", bank_en); end
      n_checks++;
      if (bank_adr[0] !== 5'd5) begin n_fail++; $display("FAIL single_adr: got %0d want 5", bank_adr[0]); end
      next_cycle();
      req = '0;
      @(negedge clk);
      n_checks++;
      if (rvalid_cpu !== 4'b0001) begin n_fail++; $display("FAIL single_rvalid: got %b want 0001", rvalid_cpu); end
      n_checks++;
      if (rd_cpu[0] !== mem[0][5]) begin n_fail++; $display("FAIL single_rd: got %h want %h", rd_cpu[0], mem[0][5]); end
      n_checks++;
      if (rerr_cpu !== '0) begin n_fail++; $display("FAIL single_rerr: got %b want 0", rerr_cpu); end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (rvalid_cpu !== '0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", rvalid_cpu); end
      n_checks++;
      if (rd_cpu[0] !== mem[0][5]) begin n_fail++; $display("FAIL single_hold: got %h want %h", rd_cpu[0], mem[0][5]); end
      next_cycle();
   endtask

   task automatic test_contention();
      logic [NP-1:0] e;
      int k;
      do_reset();
      for (int p = 0; p < NP; p++) ra[p] = AW'(40 + p);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         k = i % NP;
         e = 4'b0001 << k;
         n_checks++;
         if (gnt_cpu !== e) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, gnt_cpu, e); end
         n_checks++;
         if (bank_en !== 3'b010) begin n_fail++; $display("FAIL cont_en[%0d]: got %b want 010", i, bank_en); end
         n_checks++;
         if (bank_adr[1] !== OW'(8 + k)) begin n_fail++; $display("FAIL cont_adr[%0d]: got %0d want %0d", i, bank_adr[1], 8 + k); end
         if (i > 0) begin
            k = (i - 1) % NP;
            e = 4'b0001 << k;
            n_checks++;
            if (rvalid_cpu !== e) begin n_fail++; $display("FAIL cont_rvalid[%0d]: got %b want %b", i, rvalid_cpu, e); end
            n_checks++;
            if (rd_cpu[k] !== mem[1][8 + k]) begin n_fail++; $display("FAIL cont_rd[%0d]: got %h want %h", i, rd_cpu[k], mem[1][8 + k]); end
         end
         next_cycle();
      end
      req = '0;
      @(negedge clk);
      n_checks++;
      if (rvalid_cpu !== 4'b0001) begin n_fail++; $display("FAIL cont_wrap_rvalid: got %b want 0001", rvalid_cpu); end
      next_cycle();
   endtask

   task automatic test_parallel();
      do_reset();
      ra[0] = 7'd1;
      ra[1] = 7'd33;
      ra[2] = 7'd65;
      ra[3] = 7'd127;
      req   = 4'b0111;
      @(negedge clk);
      n_checks++;
      if (gnt_cpu !== 4'b0111) begin n_fail++; $display("FAIL par_gnt: got %b want 0111", gnt_cpu); end
      n_checks++;
      if (bank_en !== 3'b111) begin n_fail++; $display("FAIL par_en: got %b want 111", bank_en); end
      n_checks++;
      if (bank_adr !== {5'd1, 5'd1, 5'd1}) begin n_fail++; $display("FAIL par_adr: got %h want 0421", bank_adr); end
      next_cycle();
      req = '0;
      @(negedge clk);
      n_checks++;
      if (rvalid_cpu !== 4'b0111) begin n_fail++; $display("FAIL par_rvalid: got %b want 0111", rvalid_cpu); end
      for (int b = 0; b < NB; b++) begin
         n_checks++;
         if (rd_cpu[b] !== mem[b][1]) begin n_fail++; $display("FAIL par_rd[%0d]: got %h want %h", b, rd_cpu[b], mem[b][1]); end
      end
      next_cycle();
   endtask

   task automatic test_oor();
      do_reset();
      ra[3] = 7'd10;
      req   = 4'b1000;
      next_cycle();
      req = '0;
      @(negedge clk);
      n_checks++;
      if (rd_cpu[3] !== mem[0][10]) begin n_fail++; $display("FAIL oor_pre_rd: got %h want %h", rd_cpu[3], mem[0][10]); end
      next_cycle();
      ra[0] = 7'd0;
      ra[1] = 7'd2;
      ra[3] = 7'd96;
      req   = 4'b1011;
      @(negedge clk);
      n_checks++;
      if (gnt_cpu !== 4'b1001) begin n_fail++; $display("FAIL oor_gnt: got %b want 1001", gnt_cpu); end
      n_checks++;
      if (bank_en !== 3'b001) begin n_fail++; $display("FAIL oor_en: got %b want 001", bank_en); end
      n_checks++;
      if (bank_adr[0] !== 5'd0) begin n_fail++; $display("FAIL oor_adr: got %0d want 0", bank_adr[0]); end
      next_cycle();
      req = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (rvalid_cpu !== 4'b1001) begin n_fail++; $display("FAIL oor_rvalid: got %b want 1001", rvalid_cpu); end
      n_checks++;
      if (rerr_cpu !== 4'b1000) begin n_fail++; $display("FAIL oor_rerr: got %b want 1000", rerr_cpu); end
      n_checks++;
      if (rd_cpu[3] !== 32'd0) begin n_fail++; $display("FAIL oor_rd: got %h want 0", rd_cpu[3]); end
      n_checks++;
      if (gnt_cpu !== 4'b0010 || bank_adr[0] !== 5'd2) begin
         n_fail++; $display("FAIL oor_next: got gnt %b adr %0d want 0010 2", gnt_cpu, bank_adr[0]);
      end
      next_cycle();
      req = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      ra[1] = 7'd2;
      req   = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (gnt_cpu !== 4'b0010) begin n_fail++; $display("FAIL rmid_gnt: got %b want 0010", gnt_cpu); end
      next_cycle();
      rst = 1'b0;
      for (int p = 0; p < NP; p++) ra[p] = AW'(p);
      req = 4'b1111;
      @(negedge clk);
      n_checks++;
      if (rvalid_cpu !== '0) begin n_fail++; $display("FAIL rmid_rvalid: got %b want 0", rvalid_cpu); end
      n_checks++;
      if (gnt_cpu !== '0 || bank_en !== '0) begin n_fail++; $display("FAIL rmid_force: got gnt %b en %b want 0 0", gnt_cpu, bank_en); end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (gnt_cpu !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr: got %b want 0001", gnt_cpu); end
      n_checks++;
      if (rvalid_cpu !== '0) begin n_fail++; $display("FAIL rmid_rvalid2: got %b want 0", rvalid_cpu); end
      n_checks++;
      if (rd_cpu[1] !== 32'd0) begin n_fail++; $display("FAIL rmid_rd: got %h want 0", rd_cpu[1]); end
      next_cycle();
      req = '0;
   endtask

   task automatic test_random();
      int            mptr [NB];
      int            win  [NB];
      logic [NP-1:0]         m_rv, m_err, e_gnt, e_oor;
      logic [NP-1:0][31:0]   m_rd;
      logic [NB-1:0]         e_en;
      logic [NB-1:0][OW-1:0] e_adr;
      int a, d, bestd;
      do_reset();
      for (int b = 0; b < NB; b++) mptr[b] = 0;
      m_rv  = '0;
      m_err = '0;
      m_rd  = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         e_gnt = '0;
         e_oor = '0;
         e_en  = '0;
         e_adr = '0;
         for (int p = 0; p < NP; p++) begin
            a = int'(ra[p]);
            if (req[p] && a >= TOT) begin
               e_gnt[p] = 1'b1;
               e_oor[p] = 1'b1;
            end
         end
         for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            bestd  = NP;
            for (int p = 0; p < NP; p++) begin
               a = int'(ra[p]);
               if (req[p] && a < TOT && a / SB == b) begin
                  d = (p - mptr[b] + NP) % NP;
                  if (d < bestd) begin
                     bestd  = d;
                     win[b] = p;
                  end
               end
            end
            if (win[b] >= 0) begin
               e_gnt[win[b]] = 1'b1;
               e_en[b]       = 1'b1;
               e_adr[b]      = OW'(int'(ra[win[b]]) % SB);
            end
         end
         n_checks++;
         if (gnt_cpu !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, gnt_cpu, e_gnt); end
         n_checks++;
         if (bank_en !== e_en) begin n_fail++; $display("FAIL rnd_en@%0d: got %b want %b", cyc, bank_en, e_en); end
         n_checks++;
         if (bank_adr !== e_adr) begin n_fail++; $display("FAIL rnd_adr@%0d: got %h want %h", cyc, bank_adr, e_adr); end
         n_checks++;
         if (rvalid_cpu !== m_rv) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %b want %b", cyc, rvalid_cpu, m_rv); end
         n_checks++;
         if (rerr_cpu !== m_err) begin n_fail++; $display("FAIL rnd_rerr@%0d: got %b want %b", cyc, rerr_cpu, m_err); end
         n_checks++;
         if (rd_cpu !== m_rd) begin n_fail++; $display("FAIL rnd_rd@%0d: got %h want %h", cyc, rd_cpu, m_rd); end
         m_rv  = e_gnt;
         m_err = e_oor;
         for (int p = 0; p < NP; p++) begin
            if (e_gnt[p]) begin
               a = int'(ra[p]);
               m_rd[p] = e_oor[p] ? 32'd0 : mem[a / SB][a % SB];
            end
         end
         for (int b = 0; b < NB; b++) begin
            if (win[b] >= 0) mptr[b] = (win[b] + 1) % NP;
         end
         next_cycle();
         for (int p = 0; p < NP; p++) begin
            if (e_gnt[p]) begin
               if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
               else ra[p] = AW'($urandom_range(0, 111));
            end else if (!req[p]) begin
               if ($urandom_range(0, 9) < 4) begin
                  req[p] = 1'b1;
                  ra[p]  = AW'($urandom_range(0, 111));
               end else begin
                  ra[p] = AW'($urandom);
               end
            end
         end
      end
      req = '0;
   endtask

`ifdef BANK_RD_SCHED_STATS_EN
   task automatic test_stats();
      do_reset();
      @(negedge clk);
      n_checks++;
      if (conflict_cnt !== '0) begin n_fail++; $display("FAIL stats_rst: got %h want 0", conflict_cnt); end
      next_cycle();
      ra[0] = 7'd64;
      ra[1] = 7'd65;
      ra[2] = 7'd0;
      req   = 4'b0111;
      for (int i = 0; i < 3; i++) next_cycle();
      req = '0;
      @(negedge clk);
      n_checks++;
      if (conflict_cnt[2] !== 16'd3) begin n_fail++; $display("FAIL stats_b2: got %0d want 3", conflict_cnt[2]); end
      n_checks++;
      if (conflict_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL stats_b0: got %0d want 0", conflict_cnt[0]); end
      next_cycle();
   endtask
`endif

   initial begin
      rst = 1'b0;
      req = '0;
      ra  = '0;
      for (int b = 0; b < NB; b++) begin
         for (int w = 0; w < SB; w++) mem[b][w] = $urandom;
      end
      test_reset();
      test_single();
      test_contention();
      test_parallel();
      test_oor();
      test_reset_mid();
      test_random();
`ifdef BANK_RD_SCHED_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bank_rd_sched.md
BANK_RD_SCHED -- requirements
Module: bank_rd_sched

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 3, number of memory banks.
REQ-002 SHALL have parameter SIZE_BANKI, default 32, words per bank.
REQ-003 SHALL have parameter NUM_RD_PORTS, default 8, CPU read ports (range 2..8).
REQ-004 SHALL have derived parameters SHIRINA_BANKI = $clog2(SIZE_BANKI) and SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI*NUM_BANKS).
REQ-005 SHALL use one clock and a synchronous, active-low reset. Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- req_cpu  in  [NUM_RD_PORTS]  read request per port, held until granted.
- ra  in  [NUM_RD_PORTS][SHIRINA_VSEH_BANOK]  global word address per port.
- gnt_cpu  out  [NUM_RD_PORTS]  grant, combinational, same cycle as the accepted request.
- rvalid_cpu  out  [NUM_RD_PORTS]  registered read-data valid, one-cycle pulse.
- rerr_cpu  out  [NUM_RD_PORTS]  registered out-of-range error, qualified by rvalid_cpu.
- rd_cpu  out  [NUM_RD_PORTS][32]  registered read data.
- bank_en  out  [NUM_BANKS]  bank read enable.
- bank_adr  out  [NUM_BANKS][SHIRINA_BANKI]  local bank address.
- bank_rd  in  [NUM_BANKS][32]  combinational bank read data for bank_adr.
- conflict_cnt  out  [NUM_BANKS][16]  per-bank conflict counter (only with REQ-020 macro).

Function
REQ-006 SHALL map addresses contiguously: bank = ra / SIZE_BANKI and offset = ra % SIZE_BANKI.
REQ-007 SHALL treat ra >= NUM_BANKS*SIZE_BANKI as out of range.
REQ-008 SHALL run one round-robin arbiter per bank over the in-range requesters targeting that bank, and SHALL grant at most one port per bank per cycle.
REQ-009 SHALL, per bank, search from pointer ptr[b] upward, wrapping modulo NUM_RD_PORTS, and grant the first requesting port p.
REQ-010 SHALL set ptr[b] to (p+1) mod NUM_RD_PORTS on the next edge after a grant, and SHALL leave ptr[b] unchanged when the bank has no grant.
REQ-011 SHALL, in a granting cycle, drive bank_en[b]=1 and bank_adr[b]=offset of p; otherwise bank_en[b]=0 and bank_adr[b]=0.
REQ-012 SHALL register bank_rd[b] into rd_cpu[p] and assert rvalid_cpu[p]=1 on the edge after the grant (latency 1); rd_cpu holds its value when rvalid_cpu=0.
REQ-013 SHALL grant an out-of-range request in the same cycle, irrespective of bank traffic, then on the next cycle drive rvalid_cpu=1, rerr_cpu=1 and rd_cpu=0, with no bank_en.
REQ-014 SHALL grant requests to different banks in the same cycle, with no interaction between them.
REQ-015 SHALL bound the wait of a continuously requesting port to NUM_RD_PORTS-1 cycles.
REQ-016 SHALL ignore ra of ports with req_cpu=0, and SHALL treat a request held after its grant as a new request.

Reset
REQ-017 SHALL, while rst=0, force gnt_cpu=0 and bank_en=0.
REQ-018 SHALL, on an edge with rst=0, clear all ptr, rvalid_cpu, rerr_cpu, rd_cpu and conflict_cnt to 0.
REQ-019 SHALL drop a read granted in the cycle before reset: rvalid_cpu stays 0.

Configuration
REQ-020 SHALL, with macro BANK_RD_SCHED_STATS_EN defined, increment conflict_cnt[b] every cycle in which two or more in-range requests target bank b.
REQ-021 SHALL saturate conflict_cnt[b] at 16'hFFFF.
REQ-022 SHALL, without BANK_RD_SCHED_STATS_EN, omit the conflict_cnt port and its logic entirely.

Structure
REQ-023 SHALL place DATA_W=32, CNT_W=16 and the bank/offset decode functions in package bank_rd_sched_pkg.
REQ-024 SHALL implement per-bank arbitration as sub-module rr_arb (request vector in, one-hot grant and pointer register inside), instantiated NUM_BANKS times.

Verification (NUM_BANKS=3, SIZE_BANKI=32, NUM_RD_PORTS=4)
REQ-025 Single request: port0 ra=5 -> gnt_cpu=4'b0001 and bank_en[0]=1 with bank_adr[0]=5 the same cycle; next cycle rvalid_cpu[0]=1 and rd_cpu[0]=mem0[5].
REQ-026 Same-bank contention: ports0..3 hold ra=40,41,42,43 -> grants to ports 0,1,2,3 in consecutive cycles, then port 0 again (pointer wraps); bank_adr[1]=8,9,10,11.
REQ-027 Parallel banks: port0 ra=1, port1 ra=33, port2 ra=65 -> gnt_cpu=4'b0111 in one cycle and all three rvalid_cpu bits set next cycle.
REQ-028 Out of range: port3 ra=96 while bank 0 is contended -> gnt_cpu[3]=1 the same cycle; next cycle rerr_cpu[3]=1, rd_cpu[3]=0, and no bank_en for this request.
REQ-029 Reset mid-operation: rst=0 on the cycle after a grant -> rvalid_cpu=0; after rst=1, port0 wins first (ptr=0).
REQ-030 Statistics (macro on): 3 cycles of a 2-way conflict on bank 2 -> conflict_cnt[2]=3; preloaded near max -> holds at 16'hFFFF.
